// File: rtl/board_pkg.sv
// Shared board geometry, FSM state type and character codes
// for the frame buffer controller and its address counter.
package board_pkg;

  localparam int N      = 32;
  localparam int W      = 8;
  localparam int ADDR_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    PENDING
  } fbc_state_t;

  localparam logic [7:0] CH_BLANK = 8'd32;
  localparam logic [7:0] CH_SOLID = 8'd35;
  localparam logic [7:0] CH_FILL  = 8'd70;

endpackage

// File: rtl/frame_addr_counter.sv
// Row-major cell address counter for the back-bank load;
// clr wins over inc, clr+inc lands on (0,1).
module frame_addr_counter #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  output logic [$clog2(N)-1:0] row,
  output logic [$clog2(N)-1:0] col,
  output logic                 last
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] MAX = AW'(N - 1);

  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;

  // next address: restart, or advance col then row
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = AW'(inc);
    end else if (inc) begin
      if (col_q == MAX) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // address register
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == MAX) && (col_q == MAX);

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffer controller: loads the back bank, swaps banks
// only at the end of a scanner refresh pass.
module frame_buffer_ctrl #(
  parameter int N = board_pkg::N,
  parameter int W = board_pkg::W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 byte_valid,
  input  logic [W-1:0]         byte_data,
  input  logic                 scan_pass_done,
  input  logic                 clear_err,
  output logic                 wr_en,
  output logic                 wr_bank,
  output logic [$clog2(N)-1:0] wr_row,
  output logic [$clog2(N)-1:0] wr_col,
  output logic [W-1:0]         wr_data,
  output logic                 rd_bank,
  output logic                 frame_ready,
  output logic                 short_frame,
  output logic                 overrun,
  output logic [7:0]           frame_count
);

  import board_pkg::*;

  localparam int AW = $clog2(N);

  fbc_state_t    state_q, state_d;
  logic          bank_q, bank_d;
  logic [7:0]    count_q, count_d;
  logic          ready_q, ready_d;
  logic          short_q, short_d;
  logic          ovr_q, ovr_d;
  logic          def_q, def_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_row_q, wr_row_d;
  logic [AW-1:0] wr_col_q, wr_col_d;
  logic [W-1:0]  wr_data_q, wr_data_d;

  logic          cnt_clr, cnt_inc, cnt_last;
  logic [AW-1:0] cnt_row, cnt_col;

  frame_addr_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .row   (cnt_row),
    .col   (cnt_col),
    .last  (cnt_last)
  );

  // load/swap FSM, sticky flags and write-port next values
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    count_d   = count_q;
    ready_d   = ready_q;
    short_d   = short_q & ~clear_err;
    ovr_d     = ovr_q & ~clear_err;
    def_d     = def_q;
    wr_en_d   = 1'b0;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = LOADING;
          cnt_clr = 1'b1;
        end
      end
      LOADING: begin
        if (frame_start) begin
          short_d = 1'b1;
          cnt_clr = 1'b1;
        end
        if (byte_valid) begin
          cnt_inc   = 1'b1;
          wr_en_d   = 1'b1;
          wr_data_d = byte_data;
          wr_row_d  = frame_start ? '0 : cnt_row;
          wr_col_d  = frame_start ? '0 : cnt_col;
          if (cnt_last && !frame_start) begin
            state_d = PENDING;
            ready_d = 1'b1;
          end
        end
      end
      PENDING: begin
        if (byte_valid) ovr_d = 1'b1;
        if (scan_pass_done) begin
          bank_d  = ~bank_q;
          count_d = count_q + 8'd1;
          ready_d = 1'b0;
          def_d   = 1'b0;
          if (def_q || frame_start) begin
            state_d = LOADING;
            cnt_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (frame_start) begin
          def_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bank_q    <= 1'b1;
      count_q   <= '0;
      ready_q   <= 1'b0;
      short_q   <= 1'b0;
      ovr_q     <= 1'b0;
      def_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      short_q   <= short_d;
      ovr_q     <= ovr_d;
      def_q     <= def_d;
      wr_en_q   <= wr_en_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_bank     = bank_q;
  assign rd_bank     = ~bank_q;
  assign wr_row      = wr_row_q;
  assign wr_col      = wr_col_q;
  assign wr_data     = wr_data_q;
  assign frame_ready = ready_q;
  assign short_frame = short_q;
  assign overrun     = ovr_q;
  assign frame_count = count_q;

endmodule
